// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - snoop side of a shared-bus MSI cache for one core
//
// Purpose: keeps a private tag/state array mirroring the core's direct-mapped
// cache and answers other cores' bus misses. It reports sharing, flushes
// Modified lines through a request/acknowledge handshake and invalidates
// lines on write misses. Transactions carrying this core's own ID are ignored.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   snoop_valid, proc_ID_in,    bus transaction strobe, requester ID,
//   address_in, rd_wr_in        address and type (1 = read miss, 0 = write miss)
//   shared_out                  line present after the snoop (valid with snoop_done)
//   wrbk_req, wrbk_addr,        write-back request and line address (held until ack),
//   wrbk_ack                    memory acknowledge pulse
//   inval_pulse                 one-cycle pulse when a line drops to I
//   snoop_busy, snoop_done      FSM not idle, one-cycle completion pulse
//   local_upd_en/addr/state,    core-side tag/state update and its acceptance
//   local_upd_ready
//   local_rd_addr,              core-side combinational state lookup
//   local_rd_state
module snoop_responder #(
   parameter logic [1:0] MY_ID     = 2'd0,
   parameter int         NUM_LINES = 16,
   parameter int         OFFSET_W  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snoop_valid,
   input  logic [1:0]  proc_ID_in,
   input  logic [31:0] address_in,
   input  logic        rd_wr_in,
   output logic        shared_out,
   output logic        wrbk_req,
   output logic [31:0] wrbk_addr,
   input  logic        wrbk_ack,
   output logic        inval_pulse,
   output logic        snoop_busy,
   output logic        snoop_done,
   input  logic        local_upd_en,
   input  logic [31:0] local_upd_addr,
   input  logic [1:0]  local_upd_state,
   output logic        local_upd_ready,
   input  logic [31:0] local_rd_addr,
   output logic [1:0]  local_rd_state
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - OFFSET_W - IDX_W;

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_FLUSH,
      S_DONE
   } fsm_t;

   fsm_t             fsm;
   logic [TAG_W-1:0] tag_mem   [NUM_LINES];
   logic [1:0]       state_mem [NUM_LINES];

   logic [TAG_W-1:0] cap_tag;
   logic [IDX_W-1:0] cap_idx;
   logic             cap_rd;

   // Lookup of the captured snoop address.
   logic [1:0] lk_state;
   logic       lk_tag_hit;
   logic       lk_s;
   logic       lk_m;

   assign lk_state   = state_mem[cap_idx];
   assign lk_tag_hit = (tag_mem[cap_idx] == cap_tag);
   assign lk_s       = lk_tag_hit && (lk_state == ST_S);
   assign lk_m       = lk_tag_hit && (lk_state == ST_M);

   // Core-side update: blocked only when it targets the line the snoop owns.
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic [1:0]       upd_state_norm;
   logic             upd_we;

   assign upd_idx         = local_upd_addr[OFFSET_W +: IDX_W];
   assign upd_tag         = local_upd_addr[31 -: TAG_W];
   assign local_upd_ready = !snoop_busy || (upd_idx != cap_idx);
   assign upd_we          = local_upd_en && local_upd_ready;
   // The reserved encoding is stored as I so every later check sees only I/S/M.
   assign upd_state_norm  = ((local_upd_state == ST_S) || (local_upd_state == ST_M)) ?
                            local_upd_state : ST_I;

   // Core-side combinational lookup.
   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [1:0]       rd_st;

   assign rd_idx         = local_rd_addr[OFFSET_W +: IDX_W];
   assign rd_tag         = local_rd_addr[31 -: TAG_W];
   assign rd_st          = state_mem[rd_idx];
   assign local_rd_state = ((tag_mem[rd_idx] == rd_tag) && ((rd_st == ST_S) || (rd_st == ST_M))) ?
                           rd_st : ST_I;

   // Byte-offset bits carry no meaning for line-granular tracking.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{address_in[OFFSET_W-1:0], local_upd_addr[OFFSET_W-1:0],
                                 local_rd_addr[OFFSET_W-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= S_IDLE;
         cap_tag     <= '0;
         cap_idx     <= '0;
         cap_rd      <= 1'b0;
         shared_out  <= 1'b0;
         wrbk_req    <= 1'b0;
         wrbk_addr   <= '0;
         inval_pulse <= 1'b0;
         snoop_busy  <= 1'b0;
         snoop_done  <= 1'b0;
         for (int i = 0; i < NUM_LINES; i++) begin
            tag_mem[i]   <= '0;
            state_mem[i] <= ST_I;
         end
      end else begin
         inval_pulse <= 1'b0;
         snoop_done  <= 1'b0;

         // Never collides with the snoop writes below: while busy, the
         // snoop's index is refused to the core.
         if (upd_we) begin
            tag_mem[upd_idx]   <= upd_tag;
            state_mem[upd_idx] <= upd_state_norm;
         end

         case (fsm)
            S_IDLE: begin
               if (snoop_valid && (proc_ID_in != MY_ID)) begin
                  cap_tag    <= address_in[31 -: TAG_W];
                  cap_idx    <= address_in[OFFSET_W +: IDX_W];
                  cap_rd     <= rd_wr_in;
                  snoop_busy <= 1'b1;
                  fsm        <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (lk_m) begin
                  wrbk_req  <= 1'b1;
                  wrbk_addr <= {cap_tag, cap_idx, {OFFSET_W{1'b0}}};
                  fsm       <= S_FLUSH;
               end else if (lk_s && !cap_rd) begin
                  state_mem[cap_idx] <= ST_I;
                  inval_pulse        <= 1'b1;
                  shared_out         <= 1'b0;
                  snoop_done         <= 1'b1;
                  fsm                <= S_DONE;
               end else begin
                  shared_out <= lk_s;
                  snoop_done <= 1'b1;
                  fsm        <= S_DONE;
               end
            end
            S_FLUSH: begin
               if (wrbk_ack) begin
                  wrbk_req   <= 1'b0;
                  snoop_done <= 1'b1;
                  fsm        <= S_DONE;
                  if (cap_rd) begin
                     state_mem[cap_idx] <= ST_S;
                     shared_out         <= 1'b1;
                  end else begin
                     state_mem[cap_idx] <= ST_I;
                     shared_out         <= 1'b0;
                     inval_pulse        <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               shared_out <= 1'b0;
               snoop_busy <= 1'b0;
               fsm        <= S_IDLE;
            end
            default: begin
               fsm <= S_IDLE;
            end
         endcase
      end
   end

   // The bus serialises transactions; a strobe while busy is dropped.
   a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(snoop_valid && snoop_busy));

endmodule
